// File: rtl/pc_sequencer.sv
// Registered program-counter unit: holds the PC and selects the next PC from
// sequential, branch, jump, register-jump and exception sources.
// Optional return-address-stack checker enabled by defining PC_SEQ_RAS_EN;
// without it ras_mismatch is tied low and no stack storage exists.
module pc_sequencer #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] EXC_VECTOR   = 32'h0000_0080,
    parameter int unsigned     CNT_W        = 16,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [31:0]      instruction,
    input  logic             Jump,
    input  logic             Branch,
    input  logic             Bne,
    input  logic             zero,
    input  logic             JumpReg,
    input  logic             Link,
    input  logic [XLEN-1:0]  reg_target,
    input  logic             exc,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,
    output logic             flush,
    output logic             misalign,
    output logic [CNT_W-1:0] taken_cnt,
    output logic             ras_mismatch
);

    logic [XLEN-1:0]  pc_q;
    logic             flush_q;
    logic             misalign_q;
    logic [CNT_W-1:0] taken_cnt_q;

    logic [XLEN-1:0]  br_tgt;
    logic [XLEN-1:0]  j_tgt;
    logic [XLEN-1:0]  jr_tgt;
    logic             take_br;
    logic [XLEN-1:0]  next_pc;
    logic             redirect;

    // Bits [31:26] carry the opcode and are decoded elsewhere.
    logic unused_instr;
    assign unused_instr = ^instruction[31:26];

    assign pc_plus4 = pc_q + XLEN'(4);

    // Branch offset is a signed word offset relative to pc+4.
    assign br_tgt  = pc_plus4 + {{(XLEN - 18){instruction[15]}}, instruction[15:0], 2'b00};
    assign j_tgt   = {pc_plus4[XLEN-1:28], instruction[25:0], 2'b00};
    assign jr_tgt  = {reg_target[XLEN-1:2], 2'b00};
    assign take_br = Branch & (zero ^ Bne);

    // Next-PC priority select: exception, register jump, jump, branch, sequential.
    always_comb begin
        next_pc  = pc_plus4;
        redirect = 1'b1;
        if (exc) begin
            next_pc = EXC_VECTOR;
        end else if (JumpReg) begin
            next_pc = jr_tgt;
        end else if (Jump) begin
            next_pc = j_tgt;
        end else if (take_br) begin
            next_pc = br_tgt;
        end else begin
            redirect = 1'b0;
        end
    end

    // PC, redirect pulses and saturating redirect counter; stall holds state
    // and suppresses the one-cycle pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_VECTOR;
            flush_q     <= 1'b0;
            misalign_q  <= 1'b0;
            taken_cnt_q <= '0;
        end else if (stall) begin
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= next_pc;
            flush_q    <= redirect;
            misalign_q <= JumpReg & ~exc & (reg_target[1:0] != 2'b00);
            if (redirect && !(&taken_cnt_q)) begin
                taken_cnt_q <= taken_cnt_q + CNT_W'(1);
            end
        end
    end

    assign pc        = pc_q;
    assign flush     = flush_q;
    assign misalign  = misalign_q;
    assign taken_cnt = taken_cnt_q;

`ifdef PC_SEQ_RAS_EN
    localparam int unsigned PTR_W     = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned RAS_CNT_W = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0]      ras_mem_q [RAS_DEPTH];
    logic [PTR_W-1:0]     ras_ptr_q;
    logic [PTR_W-1:0]     ras_ptr_inc;
    logic [PTR_W-1:0]     ras_ptr_dec;
    logic [RAS_CNT_W-1:0] ras_cnt_q;
    logic                 ras_mismatch_q;
    logic                 ras_push;
    logic                 ras_pop;

    // Link selects push vs pop, so both can never be high together.
    assign ras_push    = (Jump | JumpReg) & Link & ~stall & ~exc;
    assign ras_pop     = JumpReg & ~Link & ~stall & ~exc;
    assign ras_ptr_inc = ras_ptr_q + PTR_W'(1);
    assign ras_ptr_dec = ras_ptr_q - PTR_W'(1);

    // Circular stack: ptr addresses the top entry, a full push overwrites the
    // oldest entry. The stack only checks returns; it never steers the PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            ras_ptr_q      <= '0;
            ras_cnt_q      <= '0;
            ras_mismatch_q <= 1'b0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_mem_q[i] <= '0;
            end
        end else begin
            ras_mismatch_q <= 1'b0;
            if (ras_push) begin
                ras_mem_q[ras_ptr_inc] <= pc_plus4;
                ras_ptr_q              <= ras_ptr_inc;
                if (ras_cnt_q != RAS_CNT_W'(RAS_DEPTH)) begin
                    ras_cnt_q <= ras_cnt_q + RAS_CNT_W'(1);
                end
            end else if (ras_pop && (ras_cnt_q != '0)) begin
                ras_mismatch_q <= (ras_mem_q[ras_ptr_q] != jr_tgt);
                ras_ptr_q      <= ras_ptr_dec;
                ras_cnt_q      <= ras_cnt_q - RAS_CNT_W'(1);
            end
        end
    end

    assign ras_mismatch = ras_mismatch_q;
`else
    logic unused_ras;
    assign unused_ras   = Link ^ (RAS_DEPTH == 0);
    assign ras_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default parameters).
// The return-stack steps run only when PC_SEQ_RAS_EN is defined.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [31:0] instruction;
    logic        Jump;
    logic        Branch;
    logic        Bne;
    logic        zero;
    logic        JumpReg;
    logic        Link;
    logic [31:0] reg_target;
    logic        exc;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        flush;
    logic        misalign;
    logic [15:0] taken_cnt;
    logic        ras_mismatch;

    int checks   = 0;
    int failures = 0;

    pc_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .instruction  (instruction),
        .Jump         (Jump),
        .Branch       (Branch),
        .Bne          (Bne),
        .zero         (zero),
        .JumpReg      (JumpReg),
        .Link         (Link),
        .reg_target   (reg_target),
        .exc          (exc),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .flush        (flush),
        .misalign     (misalign),
        .taken_cnt    (taken_cnt),
        .ras_mismatch (ras_mismatch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        stall       = 1'b0;
        instruction = 32'h0;
        Jump        = 1'b0;
        Branch      = 1'b0;
        Bne         = 1'b0;
        zero        = 1'b0;
        JumpReg     = 1'b0;
        Link        = 1'b0;
        reg_target  = 32'h0;
        exc         = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clr();
        step();
        step();
        chk("rst_pc", pc, 32'h0);
        chk("rst_flush", flush, 1'b0);
        chk("rst_misalign", misalign, 1'b0);
        chk("rst_cnt", taken_cnt, 16'd0);
        chk("rst_ras", ras_mismatch, 1'b0);

        // Sequential fetch after release.
        rst = 1'b0;
        chk("seq_pc0", pc, 32'h0);
        chk("seq_plus4", pc_plus4, 32'h4);
        step();
        chk("seq_pc4", pc, 32'h4);
        chk("seq_flush", flush, 1'b0);
        step();
        chk("seq_pc8", pc, 32'h8);
        repeat (62) step();
        chk("seq_pc100", pc, 32'h100);
        chk("seq_cnt", taken_cnt, 16'd0);

        // Taken beq to itself: 0x104 + (-1 << 2).
        Branch = 1'b1;
        zero = 1'b1;
        instruction = 32'h0000_FFFF;
        step();
        chk("beq_pc", pc, 32'h100);
        chk("beq_flush", flush, 1'b1);
        chk("beq_cnt", taken_cnt, 16'd1);

        // Same inputs as bne: not taken.
        Bne = 1'b1;
        step();
        chk("bne_pc", pc, 32'h104);
        chk("bne_flush", flush, 1'b0);
        chk("bne_cnt", taken_cnt, 16'd1);

        // Register jump to set up the jump region.
        clr();
        JumpReg = 1'b1;
        reg_target = 32'h4000_0010;
        step();
        chk("jr_pc", pc, 32'h4000_0010);
        chk("jr_cnt", taken_cnt, 16'd2);

        clr();
        Jump = 1'b1;
        instruction = 32'h0000_0040;
        step();
        chk("j_pc", pc, 32'h4000_0100);
        chk("j_cnt", taken_cnt, 16'd3);

        // Jump and taken branch together: jump wins (branch would give 0x4000_0204).
        Branch = 1'b1;
        zero = 1'b1;
        step();
        chk("jbr_pc", pc, 32'h4000_0100);
        chk("jbr_flush", flush, 1'b1);
        chk("jbr_cnt", taken_cnt, 16'd4);

        // Misaligned register jump.
        clr();
        JumpReg = 1'b1;
        reg_target = 32'h0000_0203;
        chk("jrm_plus4", pc_plus4, 32'h4000_0104);
        step();
        chk("jrm_pc", pc, 32'h200);
        chk("jrm_misalign", misalign, 1'b1);
        chk("jrm_ras", ras_mismatch, 1'b0);
        clr();
        step();
        chk("after_pc", pc, 32'h204);
        chk("after_misalign", misalign, 1'b0);
        chk("after_flush", flush, 1'b0);

        // Exception beats a misaligned register jump.
        JumpReg = 1'b1;
        reg_target = 32'h0000_0203;
        exc = 1'b1;
        step();
        chk("exc_pc", pc, 32'h80);
        chk("exc_misalign", misalign, 1'b0);
        chk("exc_flush", flush, 1'b1);
        chk("exc_cnt", taken_cnt, 16'd6);

        // Stall ignores a pending jump.
        clr();
        stall = 1'b1;
        Jump = 1'b1;
        instruction = 32'h0000_0040;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", pc, 32'h80);
            chk("stall_flush", flush, 1'b0);
            chk("stall_cnt", taken_cnt, 16'd6);
        end

        // Reset wins over stall.
        rst = 1'b1;
        step();
        chk("rststall_pc", pc, 32'h0);
        chk("rststall_cnt", taken_cnt, 16'd0);
        chk("rststall_flush", flush, 1'b0);
        rst = 1'b0;

        // Top-of-memory PC: pc+4 wraps to zero.
        clr();
        JumpReg = 1'b1;
        reg_target = 32'hFFFF_FFFF;
        step();
        chk("top_pc", pc, 32'hFFFF_FFFC);
        chk("top_misalign", misalign, 1'b1);
        chk("top_plus4", pc_plus4, 32'h0);
        clr();
        step();
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_flush", flush, 1'b0);

`ifdef PC_SEQ_RAS_EN
        // Return to 0x10 with an empty stack: no mismatch.
        JumpReg = 1'b1;
        reg_target = 32'h10;
        step();
        chk("ras_empty_pc", pc, 32'h10);
        chk("ras_empty", ras_mismatch, 1'b0);

        // jal at 0x10 pushes 0x14; correct return.
        clr();
        Jump = 1'b1;
        Link = 1'b1;
        instruction = 32'h0000_0100;
        step();
        chk("jal_pc", pc, 32'h400);
        clr();
        JumpReg = 1'b1;
        reg_target = 32'h14;
        step();
        chk("ret_ok", ras_mismatch, 1'b0);

        // Back to 0x10, jal again, return to the wrong address.
        reg_target = 32'h10;
        step();
        clr();
        Jump = 1'b1;
        Link = 1'b1;
        instruction = 32'h0000_0100;
        step();
        clr();
        JumpReg = 1'b1;
        reg_target = 32'h18;
        step();
        chk("ret_bad", ras_mismatch, 1'b1);
        clr();
        step();
        chk("ret_bad_pulse", ras_mismatch, 1'b0);
        chk("ret_pc", pc, 32'h1C);

        // Five jalr pushes: 0x20, 0x104, 0x204, 0x304, 0x404; oldest is overwritten.
        for (int i = 1; i <= 5; i++) begin
            JumpReg = 1'b1;
            Link = 1'b1;
            reg_target = 32'(i) << 8;
            step();
        end
        chk("push_pc", pc, 32'h500);
        Link = 1'b0;
        for (int i = 4; i >= 1; i--) begin
            JumpReg = 1'b1;
            reg_target = (32'(i) << 8) + 32'h4;
            step();
            chk("pop_match", ras_mismatch, 1'b0);
        end
        reg_target = 32'h998;
        step();
        chk("pop_empty", ras_mismatch, 1'b0);
        clr();
`else
        chk("ras_tied", ras_mismatch, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
